codec_init_sequencer: RTL



---
 rtl/codec_cfg_pkg.sv | 46 ++++
 rtl/codec_init_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec init sequencer and the I2C initializer:
// sequencer states, WM8731 register type codes and the fixed command order.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam logic [3:0] I_RESET      = 4'h0;
  localparam logic [3:0] I_ANALOG     = 4'h1;
  localparam logic [3:0] I_DIGITAL    = 4'h2;
  localparam logic [3:0] I_POWER_DOWN = 4'h3;
  localparam logic [3:0] I_DIG_FORMAT = 4'h4;
  localparam logic [3:0] I_SAMPLE     = 4'h5;
  localparam logic [3:0] I_ACTIVE     = 4'h6;
  localparam logic [3:0] I_R_PHONE    = 4'h7;
  localparam logic [3:0] I_L_PHONE    = 4'h8;
  localparam logic [3:0] I_R_LINE_IN  = 4'h9;
  localparam logic [3:0] I_L_LINE_IN  = 4'hA;

  localparam int N_CMDS = 11;

  // Power-up order: reset and power first, ACTIVE strictly last.
  function automatic logic [3:0] cmd_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return I_RESET;
      4'd1:    return I_POWER_DOWN;
      4'd2:    return I_L_LINE_IN;
      4'd3:    return I_R_LINE_IN;
      4'd4:    return I_L_PHONE;
      4'd5:    return I_R_PHONE;
      4'd6:    return I_ANALOG;
      4'd7:    return I_DIGITAL;
      4'd8:    return I_DIG_FORMAT;
      4'd9:    return I_SAMPLE;
      4'd10:   return I_ACTIVE;
      default: return I_RESET;
    endcase
  endfunction

endpackage

// File: rtl/codec_init_sequencer.sv
// Issues the 11 WM8731 register-write commands to the I2C initializer one at a
// time, with an inter-command gap, per-command timeout and bounded retries.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_done,
  output logic       o_cmd_start,
  output logic [3:0] o_cmd_type,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_error,
  output logic [3:0] o_cmd_idx
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [3:0]       LAST_IDX = 4'(N_CMDS - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_retry;
  logic [3:0]       r_idx;
  logic [3:0]       r_cmd_type;

  logic w_tmo_hit;
  logic w_gap_end;
  logic w_last_ok;
  logic w_can_retry;
  logic w_cmd_start;
  logic w_busy;
  logic w_init_done;
  logic w_error;

  // The retry count doubles as the outcome of the last command: it is cleared
  // on every finished pulse and non-zero only after a timeout.
  assign w_tmo_hit   = (r_cnt == TMO_LAST);
  assign w_gap_end   = (r_cnt == GAP_LAST);
  assign w_last_ok   = (r_retry == '0);
  assign w_can_retry = (r_retry < RTY_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_start) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_done)         w_state_next = S_GAP;
        else if (w_tmo_hit) w_state_next = w_can_retry ? S_GAP : S_ERROR;
      end
      S_GAP: begin
        if (w_gap_end)
          w_state_next = (w_last_ok && r_idx == LAST_IDX) ? S_DONE : S_ISSUE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_start = 1'b0;
    w_busy      = 1'b0;
    w_init_done = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_ISSUE: begin w_cmd_start = 1'b1; w_busy = 1'b1; end
      S_WAIT:  w_busy      = 1'b1;
      S_GAP:   w_busy      = 1'b1;
      S_DONE:  w_init_done = 1'b1;
      S_ERROR: w_error     = 1'b1;
      default: ;
    endcase
  end

  // One counter serves as the gap counter in S_GAP and the timeout timer in S_WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_retry    <= '0;
      r_idx      <= '0;
      r_cmd_type <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_cnt      <= '0;
            r_retry    <= '0;
            r_idx      <= '0;
            r_cmd_type <= cmd_rom(4'd0);
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (i_done) begin
            r_cnt   <= '0;
            r_retry <= '0;
          end else if (w_tmo_hit) begin
            r_cnt <= '0;
            if (w_can_retry) r_retry <= r_retry + RTY_W'(1);
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt <= '0;
            if (w_last_ok && r_idx != LAST_IDX) begin
              r_idx      <= r_idx + 4'd1;
              r_cmd_type <= cmd_rom(r_idx + 4'd1);
            end else if (!w_last_ok) begin
              r_cmd_type <= cmd_rom(r_idx);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_start = w_cmd_start;
  assign o_busy      = w_busy;
  assign o_init_done = w_init_done;
  assign o_error     = w_error;
  assign o_cmd_type  = r_cmd_type;
  assign o_cmd_idx   = r_idx;

endmodule
